// File: rtl/action_result_queue.sv
// Ordered buffer of matcher lookup results with a registered first-word-fall-through head.
// Define ACTION_QUEUE_STATS_EN to add saturating hit/miss/drop counters.
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 32
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif

module action_result_queue #(
    parameter int DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
    parameter int DEPTH_BITS = 3,
    parameter int NF_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] action_data_bus,
    input  logic [CTRL_WIDTH-1:0] action_ctrl_bus,
    input  logic                  action_valid,
    input  logic                  action_hit,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [CTRL_WIDTH-1:0] res_ctrl,
    output logic                  res_hit,
    output logic                  res_valid,
    input  logic                  res_rd_en,
    output logic                  nearly_full,
    output logic                  overflow
`ifdef ACTION_QUEUE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           drop_count
`endif
);

    localparam int ENTRY_W = DATA_WIDTH + CTRL_WIDTH + 1;
    localparam int DEPTH   = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   DEPTH_C = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   NF_C    = (DEPTH_BITS + 1)'(NF_THRESH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE = (DEPTH_BITS + 1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [ENTRY_W-1:0]    head_q, head_d, push_entry;
    logic                  res_valid_q, nearly_full_q, overflow_q;
    logic                  full, pop_ok, push_ok, drop, head_from_in, head_load;

    assign push_entry = {action_hit, action_ctrl_bus, action_data_bus};

    always_comb begin
        full     = (count_q == DEPTH_C);
        pop_ok   = res_rd_en & res_valid_q;
        push_ok  = action_valid & (~full | pop_ok);
        drop     = action_valid & full & ~pop_ok;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + CNT_ONE;
        else if (pop_ok && !push_ok)
            count_d = count_q - CNT_ONE;
        // The new head comes straight from the input when nothing else remains ahead of it.
        head_from_in = push_ok && (count_q == (pop_ok ? CNT_ONE : '0));
        head_load    = head_from_in || (pop_ok && (count_d != '0));
        head_d       = head_from_in ? push_entry : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            res_valid_q   <= 1'b0;
            nearly_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            if (head_load)
                head_q    <= head_d;
            res_valid_q   <= (count_d != '0);
            nearly_full_q <= ((DEPTH_C - count_d) <= NF_C);
            overflow_q    <= overflow_q | drop;
        end
    end

    assign res_hit     = head_q[ENTRY_W-1];
    assign res_ctrl    = head_q[DATA_WIDTH +: CTRL_WIDTH];
    assign res_data    = head_q[DATA_WIDTH-1:0];
    assign res_valid   = res_valid_q;
    assign nearly_full = nearly_full_q;
    assign overflow    = overflow_q;

`ifdef ACTION_QUEUE_STATS_EN
    logic [2:0] stat_ev;
    assign stat_ev = {drop, push_ok & ~action_hit, push_ok & action_hit};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [31:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt_q <= '0;
            else if (stat_ev[gi] && (cnt_q != 32'hFFFF_FFFF))
                cnt_q <= cnt_q + 32'd1;
        end
    end

    assign hit_count  = g_stat[0].cnt_q;
    assign miss_count = g_stat[1].cnt_q;
    assign drop_count = g_stat[2].cnt_q;
`endif

endmodule

// File: tb/tb_action_result_queue.sv
// Scoreboard bench for action_result_queue: stimulus queues expected entries, a monitor checks pops.
module tb_action_result_queue;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] action_data_bus = '0;
    logic [CW-1:0] action_ctrl_bus = '0;
    logic          action_valid = 1'b0;
    logic          action_hit = 1'b0;
    logic [DW-1:0] res_data;
    logic [CW-1:0] res_ctrl;
    logic          res_hit;
    logic          res_valid;
    logic          res_rd_en = 1'b0;
    logic          nearly_full;
    logic          overflow;
`ifdef ACTION_QUEUE_STATS_EN
    logic [31:0]   hit_count, miss_count, drop_count;
`endif

    action_result_queue #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH_BITS(3), .NF_THRESH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
        .action_valid(action_valid), .action_hit(action_hit),
        .res_data(res_data), .res_ctrl(res_ctrl), .res_hit(res_hit),
        .res_valid(res_valid), .res_rd_en(res_rd_en),
        .nearly_full(nearly_full), .overflow(overflow)
`ifdef ACTION_QUEUE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count), .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int model_cnt = 0;
    logic [DW+CW:0] exp_q[$];
    logic [DW+CW:0] mon_e;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens on the coming edge, so the presented head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && res_valid && res_rd_en) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL pop_unexpected: got %0h expected none", {res_hit, res_ctrl, res_data});
            end else begin
                mon_e = exp_q.pop_front();
                check("pop_entry", 64'({res_hit, res_ctrl, res_data}), 64'(mon_e));
            end
        end
    end

    task automatic cycle(bit push, bit hit, logic [DW-1:0] d, logic [CW-1:0] c, bit pop);
        bit pop_eff, acc;
        action_valid    = push;
        action_hit      = hit;
        action_data_bus = d;
        action_ctrl_bus = c;
        res_rd_en       = pop;
        pop_eff = pop && (model_cnt > 0);
        acc     = push && ((model_cnt < 8) || pop_eff);
        if (acc)
            exp_q.push_back({hit, c, d});
        model_cnt = model_cnt + int'(acc) - int'(pop_eff);
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        res_rd_en    = 1'b0;
        check("res_valid", 64'(res_valid), 64'(model_cnt != 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_hit"}, 64'(res_hit), 64'd0);
        check({tag, "_data"}, 64'(res_data), 64'd0);
        check({tag, "_ctrl"}, 64'(res_ctrl), 64'd0);
        check({tag, "_nf"}, 64'(nearly_full), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        check_all_zero("reset");
        do_reset();

        // Single push then pop.
        cycle(1, 1, 32'hA5, 8'h3, 0);
        check("t1_hit", 64'(res_hit), 64'd1);
        check("t1_data", 64'(res_data), 64'hA5);
        check("t1_ctrl", 64'(res_ctrl), 64'h3);
        cycle(0, 0, 0, 0, 1);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 8; i++) begin
            cycle(1, i[0], 32'(i), 8'(i), 0);
            check("t2_nearly_full", 64'(nearly_full), 64'(i >= 6));
        end
        check("t2_ovf_before", 64'(overflow), 64'd0);
        cycle(1, 1, 32'h99, 8'h9, 0);
        check("t2_ovf_after", 64'(overflow), 64'd1);
        for (int i = 1; i <= 8; i++)
            cycle(0, 0, 0, 0, 1);
        check("t2_nf_empty", 64'(nearly_full), 64'd0);

        // Push+pop at full, then at empty.
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(1, 0, 32'h100 + 32'(i), 8'(i), 0);
        cycle(1, 1, 32'h1FF, 8'hEE, 1);
        check("t3_ovf", 64'(overflow), 64'd0);
        check("t3_nf_full", 64'(nearly_full), 64'd1);
        for (int i = 0; i < 8; i++)
            cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 32'h55, 8'h5, 1);
        check("t3_empty_pushpop", 64'(res_data), 64'h55);
        cycle(0, 0, 0, 0, 1);

        // Interleaved traffic wrapping the pointers, with idle pops.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 46; i++)
            cycle(i < 20 && (i % 5 != 4), (i % 3) == 0, 32'hC000 + 32'(i), 8'(i * 7),
                  (i % 2 == 1) || (i >= 20));
        check("t4_ovf", 64'(overflow), 64'd0);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++)
            cycle(1, 1, 32'hD0 + 32'(i), 8'hD, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_all_zero("areset");
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_idle_valid", 64'(res_valid), 64'd0);
        cycle(1, 0, 32'h77, 8'h7, 0);
        check("t5_data", 64'(res_data), 64'h77);
        cycle(0, 0, 0, 0, 1);

`ifdef ACTION_QUEUE_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'hE0 + 32'(i), 8'h1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'hF0 + 32'(i), 8'h2, 0);
        cycle(1, 1, 32'hBAD, 8'h3, 0);
        check("stat_hit", 64'(hit_count), 64'd3);
        check("stat_miss", 64'(miss_count), 64'd5);
        check("stat_drop", 64'(drop_count), 64'd1);
        dut.g_stat[2].cnt_q = 32'hFFFF_FFFF;
        cycle(1, 0, 32'hBAD, 8'h3, 0);
        check("stat_drop_sat", 64'(drop_count), 64'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
